cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter.sv | 137 +++++++++++++
 tb/tb_cdb_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-port result FIFOs feeding one registered
// broadcast slot, granted round-robin from the port after the last winner.

module cdb_fu_queue #(
    parameter int Q_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enq,
    input  logic [7:0]                    enq_tag,
    input  logic [31:0]                   enq_data,
    input  logic                          deq,
    output logic                          ready,
    output logic                          nonempty,
    output logic [7:0]                    head_tag,
    output logic [31:0]                   head_data,
    output logic [$clog2(Q_DEPTH+1)-1:0]  occ
);
    localparam int PW = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
    localparam int CW = $clog2(Q_DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(Q_DEPTH);
    localparam logic [PW-1:0] LAST = PW'(Q_DEPTH - 1);

    logic [Q_DEPTH-1:0][39:0] mem;
    logic [PW-1:0]            rd_ptr;
    logic [PW-1:0]            wr_ptr;

    // Ready looks only at registered occupancy; a same-edge dequeue never frees a slot early.
    assign ready                 = !rst && (occ < FULL);
    assign nonempty              = (occ != '0);
    assign {head_tag, head_data} = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (enq)
            mem[wr_ptr] <= {enq_tag, enq_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (enq)
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            if (deq)
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            case ({enq, deq})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end
endmodule

module cdb_arbiter #(
    parameter int NUM_FU  = 4,
    parameter int Q_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FU-1:0]     fu_valid,
    input  logic [8*NUM_FU-1:0]   fu_rs_num,
    input  logic [32*NUM_FU-1:0]  fu_data,
    output logic [NUM_FU-1:0]     fu_ready,
    output logic [7:0]            cdb_rs_num,
    output logic [31:0]           cdb_data,
    output logic [2:0]            cdb_pending
);
    localparam int PTR_W = $clog2(NUM_FU);
    localparam int CW    = $clog2(Q_DEPTH + 1);

    logic [NUM_FU-1:0]          nonempty;
    logic [NUM_FU-1:0]          deq;
    logic [NUM_FU-1:0][7:0]     head_tag;
    logic [NUM_FU-1:0][31:0]    head_data;
    logic [NUM_FU-1:0][CW-1:0]  occ;
    logic [PTR_W-1:0]           rr_ptr;
    logic [PTR_W-1:0]           grant;
    logic                       grant_vld;
    int                         pend_sum;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
        logic [7:0] tag;
        assign tag    = fu_rs_num[8*i +: 8];
        assign deq[i] = grant_vld && (grant == PTR_W'(i));

        // Tag 0 is handshaken but dropped here, so it never reaches the bus.
        cdb_fu_queue #(.Q_DEPTH(Q_DEPTH)) u_q (
            .clk       (clk),
            .rst       (rst),
            .enq       (fu_valid[i] && fu_ready[i] && (tag != 8'd0)),
            .enq_tag   (tag),
            .enq_data  (fu_data[32*i +: 32]),
            .deq       (deq[i]),
            .ready     (fu_ready[i]),
            .nonempty  (nonempty[i]),
            .head_tag  (head_tag[i]),
            .head_data (head_data[i]),
            .occ       (occ[i])
        );
    end

    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            if (!grant_vld && nonempty[(int'(rr_ptr) + k) % NUM_FU]) begin
                grant_vld = 1'b1;
                grant     = PTR_W'((int'(rr_ptr) + k) % NUM_FU);
            end
        end
    end

    always_comb begin
        pend_sum = 0;
        for (int i = 0; i < NUM_FU; i++)
            pend_sum = pend_sum + int'(occ[i]);
        cdb_pending = (pend_sum > 7) ? 3'd7 : 3'(pend_sum);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= '0;
            cdb_rs_num <= '0;
            cdb_data   <= '0;
        end else if (grant_vld) begin
            cdb_rs_num <= head_tag[grant];
            cdb_data   <= head_data[grant];
            rr_ptr     <= (grant == PTR_W'(NUM_FU - 1)) ? '0 : grant + 1'b1;
        end else begin
            cdb_rs_num <= '0;
            cdb_data   <= '0;
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, latency, ordering, backpressure,
// round-robin alternation, tag-zero drop and mid-stream reset.

module tb_cdb_arbiter;
    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   fu_valid;
    logic [31:0]  fu_rs_num;
    logic [127:0] fu_data;
    logic [3:0]   fu_ready;
    logic [7:0]   cdb_rs_num;
    logic [31:0]  cdb_data;
    logic [2:0]   cdb_pending;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cdb_arbiter #(.NUM_FU(4), .Q_DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .fu_valid    (fu_valid),
        .fu_rs_num   (fu_rs_num),
        .fu_data     (fu_data),
        .fu_ready    (fu_ready),
        .cdb_rs_num  (cdb_rs_num),
        .cdb_data    (cdb_data),
        .cdb_pending (cdb_pending)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ports();
        fu_valid  = '0;
        fu_rs_num = '0;
        fu_data   = '0;
    endtask

    task automatic set_port(input int p, input logic [7:0] tag, input logic [31:0] data);
        fu_valid[p]          = 1'b1;
        fu_rs_num[8*p +: 8]  = tag;
        fu_data[32*p +: 32]  = data;
    endtask

    task automatic do_reset();
        clear_ports();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_ports();
        set_port(0, 8'h11, 32'h5555_AAAA);
        step();
        step();
        checks++; if (fu_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want 0000", fu_ready); end
        checks++; if (cdb_rs_num !== 8'h00) begin errors++; $display("FAIL reset_tag: got %h want 00", cdb_rs_num); end
        checks++; if (cdb_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", cdb_data); end
        checks++; if (cdb_pending !== 3'd0) begin errors++; $display("FAIL reset_pending: got %0d want 0", cdb_pending); end
        clear_ports();
        rst = 1'b0;
        #1;
        checks++; if (fu_ready !== 4'b1111) begin errors++; $display("FAIL reset_ready_after: got %b want 1111", fu_ready); end
        step();
        checks++; if (cdb_rs_num !== 8'h00 || cdb_pending !== 3'd0) begin errors++; $display("FAIL reset_no_accept: tag %h pend %0d want 00/0", cdb_rs_num, cdb_pending); end
    endtask

    task automatic test_single();
        do_reset();
        set_port(0, 8'h21, 32'hDEADBEEF);
        step();
        clear_ports();
        checks++; if (cdb_rs_num !== 8'h00) begin errors++; $display("FAIL single_early: got %h want 00", cdb_rs_num); end
        checks++; if (cdb_pending !== 3'd1) begin errors++; $display("FAIL single_pend1: got %0d want 1", cdb_pending); end
        step();
        checks++; if (cdb_rs_num !== 8'h21 || cdb_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_bcast: got %h/%h want 21/deadbeef", cdb_rs_num, cdb_data); end
        checks++; if (cdb_pending !== 3'd0) begin errors++; $display("FAIL single_pend0: got %0d want 0", cdb_pending); end
        step();
        checks++; if (cdb_rs_num !== 8'h00 || cdb_data !== 32'h0) begin errors++; $display("FAIL single_after: got %h/%h want 00/0", cdb_rs_num, cdb_data); end
    endtask

    task automatic test_simultaneous();
        logic [7:0] tags [4];
        tags = '{8'h21, 8'h41, 8'h61, 8'h81};
        do_reset();
        for (int p = 0; p < 4; p++)
            set_port(p, tags[p], 32'hA000_0000 + 32'(p));
        step();
        clear_ports();
        checks++; if (cdb_pending !== 3'd4 || cdb_rs_num !== 8'h00) begin errors++; $display("FAIL simul_load: pend %0d tag %h want 4/00", cdb_pending, cdb_rs_num); end
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (cdb_rs_num !== tags[k] || cdb_data !== 32'hA000_0000 + 32'(k) || cdb_pending !== 3'(3 - k)) begin
                errors++;
                $display("FAIL simul_order[%0d]: got %h/%h pend %0d want %h/%h pend %0d",
                         k, cdb_rs_num, cdb_data, cdb_pending, tags[k], 32'hA000_0000 + 32'(k), 3 - k);
            end
        end
    endtask

    task automatic test_full_queue();
        do_reset();
        set_port(0, 8'h22, 32'h22);
        set_port(1, 8'h42, 32'h42);
        set_port(2, 8'h62, 32'h62);
        set_port(3, 8'h82, 32'h82);
        step();
        checks++; if (cdb_pending !== 3'd4 || fu_ready !== 4'b1111) begin errors++; $display("FAIL full_e1: pend %0d rdy %b want 4/1111", cdb_pending, fu_ready); end
        clear_ports();
        set_port(2, 8'h63, 32'h63);
        step();
        checks++; if (cdb_rs_num !== 8'h22 || fu_ready !== 4'b1011 || cdb_pending !== 3'd4) begin errors++; $display("FAIL full_e2: tag %h rdy %b pend %0d want 22/1011/4", cdb_rs_num, fu_ready, cdb_pending); end
        set_port(2, 8'h64, 32'h64);
        step();
        checks++; if (cdb_rs_num !== 8'h42 || fu_ready !== 4'b1011 || cdb_pending !== 3'd3) begin errors++; $display("FAIL full_e3: tag %h rdy %b pend %0d want 42/1011/3", cdb_rs_num, fu_ready, cdb_pending); end
        step();
        checks++; if (cdb_rs_num !== 8'h62 || fu_ready !== 4'b1111 || cdb_pending !== 3'd2) begin errors++; $display("FAIL full_e4: tag %h rdy %b pend %0d want 62/1111/2", cdb_rs_num, fu_ready, cdb_pending); end
        step();
        clear_ports();
        checks++; if (cdb_rs_num !== 8'h82 || cdb_pending !== 3'd2) begin errors++; $display("FAIL full_e5: tag %h pend %0d want 82/2", cdb_rs_num, cdb_pending); end
        step();
        checks++; if (cdb_rs_num !== 8'h63 || cdb_data !== 32'h63 || cdb_pending !== 3'd1) begin errors++; $display("FAIL full_e6: tag %h data %h pend %0d want 63/63/1", cdb_rs_num, cdb_data, cdb_pending); end
        step();
        checks++; if (cdb_rs_num !== 8'h64 || cdb_data !== 32'h64 || cdb_pending !== 3'd0) begin errors++; $display("FAIL full_e7: tag %h data %h pend %0d want 64/64/0", cdb_rs_num, cdb_data, cdb_pending); end
        step();
        checks++; if (cdb_rs_num !== 8'h00) begin errors++; $display("FAIL full_drained: got %h want 00", cdb_rs_num); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_port(0, 8'(8'h05 + k), 32'(32'h100 + k));
            step();
            checks++; if (fu_ready[0] !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", k, fu_ready[0]); end
            if (k > 0) begin
                checks++;
                if (cdb_rs_num !== 8'(8'h04 + k) || cdb_data !== 32'(32'hFF + k)) begin
                    errors++;
                    $display("FAIL b2b_bcast[%0d]: got %h/%h want %h/%h", k, cdb_rs_num, cdb_data, 8'(8'h04 + k), 32'(32'hFF + k));
                end
            end
        end
        clear_ports();
        step();
        checks++; if (cdb_rs_num !== 8'h08 || cdb_data !== 32'h103) begin errors++; $display("FAIL b2b_last: got %h/%h want 08/103", cdb_rs_num, cdb_data); end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp [8];
        logic [7:0] t0, t3;
        logic [3:0] r;
        exp = '{8'h01, 8'h81, 8'h02, 8'h82, 8'h03, 8'h83, 8'h04, 8'h84};
        t0 = 8'h01;
        t3 = 8'h81;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            set_port(0, t0, {24'h0, t0});
            set_port(3, t3, {24'h0, t3});
            r = fu_ready;
            step();
            if (r[0]) t0 = t0 + 8'd1;
            if (r[3]) t3 = t3 + 8'd1;
            if (c >= 1) begin
                checks++;
                if (cdb_rs_num !== exp[c-1] || cdb_data !== {24'h0, exp[c-1]}) begin
                    errors++;
                    $display("FAIL rr_grant[%0d]: got %h/%h want %h", c - 1, cdb_rs_num, cdb_data, exp[c-1]);
                end
            end
        end
        clear_ports();
    endtask

    task automatic test_tag_zero();
        do_reset();
        set_port(1, 8'h00, 32'h1234);
        #1;
        checks++; if (fu_ready[1] !== 1'b1) begin errors++; $display("FAIL tag0_ready: got %b want 1", fu_ready[1]); end
        step();
        clear_ports();
        checks++; if (cdb_pending !== 3'd0 || cdb_rs_num !== 8'h00) begin errors++; $display("FAIL tag0_e1: pend %0d tag %h want 0/00", cdb_pending, cdb_rs_num); end
        step();
        checks++; if (cdb_rs_num !== 8'h00 || cdb_data !== 32'h0 || cdb_pending !== 3'd0) begin errors++; $display("FAIL tag0_e2: got %h/%h pend %0d want 00/0/0", cdb_rs_num, cdb_data, cdb_pending); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_port(0, 8'h23, 32'h23);
        set_port(1, 8'h43, 32'h43);
        set_port(2, 8'h63, 32'h63);
        step();
        clear_ports();
        checks++; if (cdb_pending !== 3'd3) begin errors++; $display("FAIL rmid_loaded: got %0d want 3", cdb_pending); end
        rst = 1'b1;
        step();
        checks++; if (cdb_rs_num !== 8'h00 || cdb_pending !== 3'd0 || fu_ready !== 4'b0000) begin errors++; $display("FAIL rmid_edge: tag %h pend %0d rdy %b want 00/0/0000", cdb_rs_num, cdb_pending, fu_ready); end
        rst = 1'b0;
        #1;
        checks++; if (fu_ready !== 4'b1111) begin errors++; $display("FAIL rmid_ready: got %b want 1111", fu_ready); end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (cdb_rs_num !== 8'h00 || cdb_pending !== 3'd0) begin errors++; $display("FAIL rmid_quiet[%0d]: tag %h pend %0d want 00/0", k, cdb_rs_num, cdb_pending); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        clear_ports();
        test_reset();
        test_single();
        test_simultaneous();
        test_full_queue();
        test_back_to_back();
        test_round_robin();
        test_tag_zero();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
